// File: rtl/tdl_pattern_gen.sv
// Synthetic tapped-delay-line column source: encodes a bin number as a thermometer
// pattern, single-shot or as a bin sweep, with optional single-bubble injection.
module tdl_pattern_gen #(
  parameter int NUM_FF      = 128,
  parameter int BITS_DECO   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int BUBBLE_OFS  = 6
) (
  input  logic                 wClk,
  input  logic                 wRstN,
  input  logic                 wCmdValid,
  output logic                 wCmdReady,
  input  logic                 wCmdSweep,
  input  logic [BITS_DECO-1:0] wCmdBin,
  input  logic [BITS_DECO-1:0] wCmdBinEnd,
  input  logic                 wCmdBubble,
  input  logic                 wAbort,
  output logic [NUM_FF-1:0]    wPatOut,
  output logic                 wPatValid,
  output logic [BITS_DECO-1:0] wPatBin,
  output logic                 wBusy,
  output logic                 wDone,
  output logic                 wErrRange
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam int CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LOAD = (HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0;

  localparam logic [BITS_DECO-1:0] MAX_BIN = BITS_DECO'(NUM_FF - 20);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(HOLD_LOAD);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BITS_DECO-1:0] r_cur;
  logic [BITS_DECO-1:0] r_end;
  logic                 r_sweep;
  logic                 r_bubble;
  logic [NUM_FF-1:0]    r_pat;
  logic                 r_err;

  logic                 w_bin_ok;
  logic                 w_end_ok;
  logic                 w_cmd_legal;
  logic                 w_pat_end;
  logic                 w_last;
  logic [BITS_DECO-1:0] w_cur_next;

  // Ones below the edge; the optional bubble sits BUBBLE_OFS bits under the edge bit.
  function automatic logic [NUM_FF-1:0] f_pattern(input logic [BITS_DECO-1:0] bin,
                                                  input logic bubble);
    logic [NUM_FF-1:0] v;
    int b;
    b = int'(bin);
    for (int k = 0; k < NUM_FF; k++) begin
      v[k] = (k < b) && !(bubble && (b > BUBBLE_OFS) && (k == b - 1 - BUBBLE_OFS));
    end
    return v;
  endfunction

  assign w_bin_ok    = (wCmdBin != '0) && (wCmdBin <= MAX_BIN);
  assign w_end_ok    = (wCmdBinEnd >= wCmdBin) && (wCmdBinEnd <= MAX_BIN);
  assign w_cmd_legal = w_bin_ok && (!wCmdSweep || w_end_ok);

  // The EMIT cycle counts toward the hold time, so a one-cycle hold ends in EMIT itself.
  assign w_pat_end  = ((r_state == S_EMIT) && (HOLD_CYCLES == 1)) ||
                      ((r_state == S_HOLD) && (r_cnt == '0));
  assign w_last     = !r_sweep || (r_cur == r_end);
  assign w_cur_next = r_cur + BITS_DECO'(1);

  assign wCmdReady = (r_state == S_IDLE);
  assign wBusy     = (r_state != S_IDLE);
  assign wPatValid = (r_state == S_EMIT);
  assign wPatOut   = r_pat;
  assign wPatBin   = r_cur;
  assign wErrRange = r_err;
  assign wDone     = w_pat_end && w_last && !wAbort;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cur    <= '0;
      r_end    <= '0;
      r_sweep  <= 1'b0;
      r_bubble <= 1'b0;
      r_pat    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (wAbort) begin
        r_state <= S_IDLE;
        r_pat   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (wCmdValid) begin
              if (w_cmd_legal) begin
                r_cur    <= wCmdBin;
                r_end    <= wCmdBinEnd;
                r_sweep  <= wCmdSweep;
                r_bubble <= wCmdBubble;
                r_pat    <= f_pattern(wCmdBin, wCmdBubble);
                r_state  <= S_EMIT;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_EMIT, S_HOLD: begin
            if (w_pat_end) begin
              if (w_last) begin
                r_state <= S_IDLE;
                r_pat   <= '0;
              end else begin
                r_cur   <= w_cur_next;
                r_pat   <= f_pattern(w_cur_next, r_bubble);
                r_state <= S_EMIT;
              end
            end else if (r_state == S_EMIT) begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_HOLD;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_pat   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdl_pattern_gen.sv
// Scoreboard bench for tdl_pattern_gen: stimulus pushes expected strobes/pulses,
// an independent monitor pops and compares them whenever the DUT presents one.
module tb_tdl_pattern_gen;

  localparam int NUM_FF      = 128;
  localparam int BITS_DECO   = 8;
  localparam int HOLD_CYCLES = 4;
  localparam int BUBBLE_OFS  = 6;

  logic                 wClk = 1'b0;
  logic                 wRstN = 1'b0;
  logic                 wCmdValid = 1'b0;
  logic                 wCmdReady;
  logic                 wCmdSweep = 1'b0;
  logic [BITS_DECO-1:0] wCmdBin = '0;
  logic [BITS_DECO-1:0] wCmdBinEnd = '0;
  logic                 wCmdBubble = 1'b0;
  logic                 wAbort = 1'b0;
  logic [NUM_FF-1:0]    wPatOut;
  logic                 wPatValid;
  logic [BITS_DECO-1:0] wPatBin;
  logic                 wBusy;
  logic                 wDone;
  logic                 wErrRange;

  tdl_pattern_gen #(
    .NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO),
    .HOLD_CYCLES(HOLD_CYCLES), .BUBBLE_OFS(BUBBLE_OFS)
  ) dut (
    .wClk(wClk), .wRstN(wRstN), .wCmdValid(wCmdValid), .wCmdReady(wCmdReady),
    .wCmdSweep(wCmdSweep), .wCmdBin(wCmdBin), .wCmdBinEnd(wCmdBinEnd),
    .wCmdBubble(wCmdBubble), .wAbort(wAbort), .wPatOut(wPatOut),
    .wPatValid(wPatValid), .wPatBin(wPatBin), .wBusy(wBusy), .wDone(wDone),
    .wErrRange(wErrRange)
  );

  always #5 wClk = ~wClk;

  typedef enum int {EV_PAT, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t          kind;
    int                bin;
    logic [NUM_FF-1:0] pat;
  } ev_t;

  ev_t               exp_q[$];
  int                n_vec  = 0;
  int                n_fail = 0;
  logic [NUM_FF-1:0] held_pat = '0;

  task automatic check(input string name, input logic [NUM_FF-1:0] act,
                       input logic [NUM_FF-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, NUM_FF'(act), NUM_FF'(exp));
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    check(name, NUM_FF'(act), NUM_FF'(exp));
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  function automatic logic [NUM_FF-1:0] model_pat(input int bin, input bit bub);
    logic [NUM_FF-1:0] p;
    p = '0;
    for (int k = 0; k < bin; k++) p[k] = 1'b1;
    if (bub && (bin - 1 >= BUBBLE_OFS)) p[bin-1-BUBBLE_OFS] = 1'b0;
    return p;
  endfunction

  // Reference start-column decoder: first 1 followed by four 0s marks the edge.
  function automatic int decode(input logic [NUM_FF-1:0] p);
    for (int k = 0; k <= NUM_FF - 5; k++) begin
      if (p[k] && (p[k+1 +: 4] == 4'b0000)) return k + 1;
    end
    return 0;
  endfunction

  task automatic exp_pat(input int bin, input bit bub);
    ev_t e;
    e.kind = EV_PAT;
    e.bin  = bin;
    e.pat  = model_pat(bin, bub);
    exp_q.push_back(e);
  endtask

  task automatic exp_ev(input ev_kind_t k);
    ev_t e;
    e.kind = k;
    e.bin  = 0;
    e.pat  = '0;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input string name, output ev_t e,
                           output bit got);
    got = 1'b0;
    e.kind = k;
    e.bin  = 0;
    e.pat  = '0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_%s: got event expected none at %0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      check_i({name, "_kind"}, int'(k), int'(e.kind));
      got = (e.kind == k);
    end
  endtask

  // Monitor: independent of stimulus, samples on the falling edge.
  always @(negedge wClk) begin
    ev_t e;
    bit  got;
    if (wRstN) begin
      if (wPatValid) begin
        expect_ev(EV_PAT, "pat", e, got);
        if (got) begin
          check("pat_bits", wPatOut, e.pat);
          check_i("pat_bin", int'(wPatBin), e.bin);
          check_i("pat_decode", decode(wPatOut), e.bin);
        end
        held_pat = wPatOut;
      end else if (wBusy) begin
        check("hold_stable", wPatOut, held_pat);
      end else begin
        check("idle_zero", wPatOut, '0);
      end
      if (wDone)     expect_ev(EV_DONE, "done", e, got);
      if (wErrRange) expect_ev(EV_ERR, "err", e, got);
    end
  end

  task automatic tick();
    @(negedge wClk);
    #1;
  endtask

  task automatic handshake(input bit sweep, input int bin, input int bin_end,
                           input bit bub, input bit keep);
    int n;
    tick();
    wCmdSweep  = sweep;
    wCmdBin    = BITS_DECO'(bin);
    wCmdBinEnd = BITS_DECO'(bin_end);
    wCmdBubble = bub;
    wCmdValid  = 1'b1;
    n = 0;
    while (!wCmdReady && n < 2000) begin
      tick();
      n++;
    end
    if (!wCmdReady) fail_now("ready_timeout");
    @(posedge wClk);
    #1;
    if (!keep) wCmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while ((wBusy || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check_b("drain_busy", wBusy, 1'b0);
    check_i("drain_queue", exp_q.size(), 0);
  endtask

  task automatic wait_strobe(input int bin);
    int n;
    n = 0;
    tick();
    while (!(wPatValid && int'(wPatBin) == bin) && n < 1000) begin
      tick();
      n++;
    end
    if (!(wPatValid && int'(wPatBin) == bin)) fail_now("strobe_timeout");
  endtask

  initial begin
    int c;

    // Reset state
    tick();
    check("rst_pat", wPatOut, '0);
    check_b("rst_valid", wPatValid, 1'b0);
    check_b("rst_busy", wBusy, 1'b0);
    check_b("rst_done", wDone, 1'b0);
    check_b("rst_err", wErrRange, 1'b0);
    check_i("rst_bin", int'(wPatBin), 0);
    wRstN = 1'b1;
    tick();
    check_b("rst_ready", wCmdReady, 1'b1);

    // Single bin 37: pattern at N+1, held 4 cycles, wDone in the last held cycle
    exp_pat(37, 1'b0);
    exp_ev(EV_DONE);
    handshake(1'b0, 37, 0, 1'b0, 1'b0);
    tick();
    c = 1;
    check_b("s37_valid", wPatValid, 1'b1);
    check("s37_pat", wPatOut, 128'h1F_FFFF_FFFF);
    while (!wDone && c < 10) begin
      tick();
      c++;
    end
    check_i("s37_done_cycle", c, HOLD_CYCLES);
    tick();
    check("s37_cleared", wPatOut, '0);
    check_b("s37_idle", wBusy, 1'b0);
    wait_idle();

    // Full sweep 1..108
    for (int b = 1; b <= 108; b++) exp_pat(b, 1'b0);
    exp_ev(EV_DONE);
    handshake(1'b1, 1, 108, 1'b0, 1'b0);
    c = 0;
    do begin
      tick();
      c++;
    end while (!wDone && c < 1000);
    check_i("sweep_done_cycle", c, 432);
    wait_idle();

    // Illegal commands: rejected, no pattern, ready stays high
    exp_ev(EV_ERR); handshake(1'b0, 0, 0, 1'b0, 1'b0);
    tick(); check_b("err_bin0_ready", wCmdReady, 1'b1);
    exp_ev(EV_ERR); handshake(1'b0, 109, 0, 1'b0, 1'b0);
    tick(); check_b("err_bin109_ready", wCmdReady, 1'b1);
    exp_ev(EV_ERR); handshake(1'b1, 50, 40, 1'b0, 1'b0);
    tick(); check_b("err_rev_ready", wCmdReady, 1'b1);
    exp_ev(EV_ERR); handshake(1'b1, 100, 109, 1'b0, 1'b0);
    tick(); check_b("err_end_ready", wCmdReady, 1'b1);
    wait_idle();

    // Bubble injection and low/high boundaries
    exp_pat(20, 1'b1); exp_ev(EV_DONE); handshake(1'b0, 20, 0, 1'b1, 1'b0);
    tick(); check("bub20_pat", wPatOut, 128'hFDFFF);
    wait_idle();
    exp_pat(5, 1'b1); exp_ev(EV_DONE); handshake(1'b0, 5, 0, 1'b1, 1'b0);
    tick(); check("bub5_pat", wPatOut, 128'h1F);
    wait_idle();
    exp_pat(7, 1'b1); exp_ev(EV_DONE); handshake(1'b0, 7, 0, 1'b1, 1'b0);
    tick(); check("bub7_pat", wPatOut, 128'h7E);
    wait_idle();
    exp_pat(1, 1'b1); exp_ev(EV_DONE); handshake(1'b0, 1, 0, 1'b1, 1'b0);
    tick(); check("bin1_pat", wPatOut, 128'h1);
    wait_idle();
    exp_pat(108, 1'b0); exp_ev(EV_DONE); handshake(1'b0, 108, 0, 1'b0, 1'b0);
    tick(); check("bin108_pat", wPatOut, 128'h0000_0FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    wait_idle();

    // Abort at bin 50 of sweep 10..100
    for (int b = 10; b <= 50; b++) exp_pat(b, 1'b0);
    handshake(1'b1, 10, 100, 1'b0, 1'b0);
    wait_strobe(50);
    wAbort = 1'b1;
    @(posedge wClk);
    #1;
    wAbort = 1'b0;
    tick();
    check_b("abort_busy", wBusy, 1'b0);
    check("abort_pat", wPatOut, '0);
    check_b("abort_done", wDone, 1'b0);
    wait_idle();

    // Reset pulsed mid-HOLD of the same sweep
    for (int b = 10; b <= 50; b++) exp_pat(b, 1'b0);
    handshake(1'b1, 10, 100, 1'b0, 1'b0);
    wait_strobe(50);
    tick();
    check_b("rsthold_busy", wBusy, 1'b1);
    wRstN = 1'b0;
    #1;
    check("rsthold_pat", wPatOut, '0);
    check_b("rsthold_idle", wBusy, 1'b0);
    check_b("rsthold_done", wDone, 1'b0);
    tick();
    wRstN = 1'b1;
    tick();
    check_b("rsthold_ready", wCmdReady, 1'b1);
    wait_idle();

    // Abort in IDLE beats a simultaneous command (legal and illegal)
    tick();
    wCmdSweep = 1'b0; wCmdBin = 8'd30; wCmdBubble = 1'b0; wCmdValid = 1'b1; wAbort = 1'b1;
    @(posedge wClk);
    #1;
    wCmdBin = 8'd0;
    @(posedge wClk);
    #1;
    wCmdValid = 1'b0; wAbort = 1'b0;
    check_b("idle_abort_busy", wBusy, 1'b0);
    check_b("idle_abort_err", wErrRange, 1'b0);
    wait_idle();

    // wCmdValid held while busy: second command only after completion
    exp_pat(37, 1'b0); exp_ev(EV_DONE);
    exp_pat(37, 1'b0); exp_ev(EV_DONE);
    handshake(1'b0, 37, 0, 1'b0, 1'b1);
    c = 0;
    do begin
      tick();
      c++;
      if (!wDone) check_b("busy_not_ready", wCmdReady, 1'b0);
    end while (!wDone && c < 20);
    check_i("b2b_done_cycle", c, HOLD_CYCLES);
    tick();
    check_b("b2b_ready", wCmdReady, 1'b1);
    check_b("b2b_gap_valid", wPatValid, 1'b0);
    @(posedge wClk);
    #1;
    wCmdValid = 1'b0;
    tick();
    check_b("b2b_second_valid", wPatValid, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
